// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - bouncing-sprite FSM and datapath between obstacle memory and VGA plot port
// Optional obstacle probing is compiled in with `define OBSTACLE_PROBE_EN.
module sprite_engine #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int X_INIT = 80,
  parameter int Y_INIT = 60,
  parameter int TW = 26,
  parameter int TIMER_LIMIT = 1_000_000,
  parameter logic [CW-1:0] SPRITE_COLOR = 3'b010
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [CW-1:0] mem_color,
  output logic [XW-1:0] mem_x,
  output logic [YW-1:0] mem_y,
  output logic          plot,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] plot_color,
  output logic          xdir,
  output logic          ydir,
  output logic          busy
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DRAW    = 4'd1;
  localparam logic [3:0] S_WAIT    = 4'd2;
  localparam logic [3:0] S_ERASE   = 4'd3;
  localparam logic [3:0] S_PROBE_X = 4'd4;
  localparam logic [3:0] S_CHK_X   = 4'd5;
  localparam logic [3:0] S_PROBE_Y = 4'd6;
  localparam logic [3:0] S_CHK_Y   = 4'd7;
  localparam logic [3:0] S_UPDATE  = 4'd8;

  localparam logic [XW-1:0] X_MAX_V  = XW'(X_MAX);
  localparam logic [YW-1:0] Y_MAX_V  = YW'(Y_MAX);
  localparam logic [XW-1:0] X_INIT_V = XW'(X_INIT);
  localparam logic [YW-1:0] Y_INIT_V = YW'(Y_INIT);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [YW-1:0] Y_ONE    = YW'(1);
  localparam logic [XW-1:0] X_ZERO   = '0;
  localparam logic [YW-1:0] Y_ZERO   = '0;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMER_LIMIT - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  logic [3:0]    state;
  logic [XW-1:0] xpos;
  logic [YW-1:0] ypos;
  logic [TW-1:0] timer;
  logic          x_edge;
  logic          y_edge;
  logic          x_block;
  logic          y_block;
  logic [XW-1:0] x_step;
  logic [YW-1:0] y_step;

  // Edge detection keeps every address and position inside the screen.
  assign x_edge = xdir ? (xpos == X_MAX_V) : (xpos == X_ZERO);
  assign y_edge = ydir ? (ypos == Y_MAX_V) : (ypos == Y_ZERO);
  assign x_step = xdir ? (xpos + X_ONE) : (xpos - X_ONE);
  assign y_step = ydir ? (ypos + Y_ONE) : (ypos - Y_ONE);

`ifdef OBSTACLE_PROBE_EN
  logic xblk;
  logic yblk;

  assign x_block = xblk;
  assign y_block = yblk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xblk <= 1'b0;
      yblk <= 1'b0;
    end else begin
      if (state == S_CHK_X) xblk <= x_edge | (mem_color != '0);
      if (state == S_CHK_Y) yblk <= y_edge | (mem_color != '0);
    end
  end

  always_comb begin
    mem_x = xpos;
    mem_y = ypos;
    if (state == S_PROBE_X && !x_edge) mem_x = x_step;
    if (state == S_PROBE_Y && !y_edge) mem_y = y_step;
  end
`else
  logic unused_mem_color;

  assign unused_mem_color = ^mem_color;
  assign x_block = x_edge;
  assign y_block = y_edge;
  assign mem_x   = xpos;
  assign mem_y   = ypos;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      xpos  <= X_INIT_V;
      ypos  <= Y_INIT_V;
      xdir  <= 1'b1;
      ydir  <= 1'b1;
      timer <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            xpos  <= X_INIT_V;
            ypos  <= Y_INIT_V;
            xdir  <= 1'b1;
            ydir  <= 1'b1;
            timer <= '0;
            state <= S_DRAW;
          end
        end
        S_DRAW: state <= S_WAIT;
        S_WAIT: begin
          if (timer == T_LAST) begin
            timer <= '0;
            state <= run ? S_ERASE : S_IDLE;
          end else begin
            timer <= timer + T_ONE;
          end
        end
`ifdef OBSTACLE_PROBE_EN
        S_ERASE:   state <= S_PROBE_X;
        S_PROBE_X: state <= S_CHK_X;
        S_CHK_X:   state <= S_PROBE_Y;
        S_PROBE_Y: state <= S_CHK_Y;
        S_CHK_Y:   state <= S_UPDATE;
`else
        S_ERASE:   state <= S_UPDATE;
`endif
        S_UPDATE: begin
          if (x_block) xdir <= ~xdir;
          else         xpos <= x_step;
          if (y_block) ydir <= ~ydir;
          else         ypos <= y_step;
          state <= S_DRAW;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign plot       = (state == S_DRAW) || (state == S_ERASE);
  assign plot_color = (state == S_DRAW) ? SPRITE_COLOR : '0;
  assign x          = xpos;
  assign y          = ypos;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - directed checks of sprite_engine framing, bouncing, run drop and reset
module tb_sprite_engine;

`ifdef OBSTACLE_PROBE_EN
  localparam int P = 11;
`else
  localparam int P = 7;
`endif

  logic clk = 0;
  logic reset = 1;
  logic run = 0;
  logic run_b = 0;
  logic [2:0] mem_a = 0;
  logic [2:0] mem_zero = 0;

  logic [7:0] a_mem_x, a_x, e_mem_x, e_x, c_mem_x, c_x;
  logic [6:0] a_mem_y, a_y, e_mem_y, e_y, c_mem_y, c_y;
  logic [2:0] a_col, e_col, c_col;
  logic a_plot, a_xdir, a_ydir, a_busy;
  logic e_plot, e_xdir, e_ydir, e_busy;
  logic c_plot, c_xdir, c_ydir, c_busy;

  int checks = 0;
  int failures = 0;
  int plots;

  always #5 clk = ~clk;

  sprite_engine #(.TIMER_LIMIT(4)) u_dut (
    .clk(clk), .reset(reset), .run(run), .mem_color(mem_a),
    .mem_x(a_mem_x), .mem_y(a_mem_y), .plot(a_plot), .x(a_x), .y(a_y),
    .plot_color(a_col), .xdir(a_xdir), .ydir(a_ydir), .busy(a_busy));

  sprite_engine #(.TIMER_LIMIT(4), .X_INIT(159), .Y_INIT(60)) u_edge (
    .clk(clk), .reset(reset), .run(run_b), .mem_color(mem_zero),
    .mem_x(e_mem_x), .mem_y(e_mem_y), .plot(e_plot), .x(e_x), .y(e_y),
    .plot_color(e_col), .xdir(e_xdir), .ydir(e_ydir), .busy(e_busy));

  sprite_engine #(.TIMER_LIMIT(4), .X_INIT(159), .Y_INIT(119)) u_corner (
    .clk(clk), .reset(reset), .run(run_b), .mem_color(mem_zero),
    .mem_x(c_mem_x), .mem_y(c_mem_y), .plot(c_plot), .x(c_x), .y(c_y),
    .plot_color(c_col), .xdir(c_xdir), .ydir(c_ydir), .busy(c_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2);
    check("rst_plot", a_plot, 0);
    check("rst_busy", a_busy, 0);
    check("rst_x", a_x, 80);
    check("rst_y", a_y, 60);
    check("rst_mem_x", a_mem_x, 80);
    check("rst_mem_y", a_mem_y, 60);
    check("rst_color", a_col, 0);
    check("rst_dirs", {a_xdir, a_ydir}, 2'b11);

    // edge and corner instances
    reset = 0;
    run_b = 1;
    step(1);
    check("edge_draw0", {e_plot, e_x, e_y}, {1'b1, 8'd159, 7'd60});
    step(P);
    check("edge_f1", {e_plot, e_x, e_y, e_xdir}, {1'b1, 8'd159, 7'd61, 1'b0});
    check("corner_f1", {c_plot, c_x, c_y, c_xdir, c_ydir}, {1'b1, 8'd159, 7'd119, 2'b00});
    step(P);
    check("edge_f2", {e_plot, e_x, e_y}, {1'b1, 8'd158, 7'd62});
    check("corner_f2", {c_plot, c_x, c_y}, {1'b1, 8'd158, 7'd118});
    run_b = 0;

    // main frame
    run = 1;
    step(1);
    check("draw0", {a_plot, a_x, a_y, a_col, a_busy}, {1'b1, 8'd80, 7'd60, 3'b010, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("wait_plot", {a_plot, a_busy}, 2'b01);
    end
    step(1);
    check("erase0", {a_plot, a_x, a_y, a_col}, {1'b1, 8'd80, 7'd60, 3'b000});
`ifdef OBSTACLE_PROBE_EN
    step(1);
    check("probe_x_addr", {a_mem_x, a_mem_y}, {8'd81, 7'd60});
    step(2);
    check("probe_y_addr", {a_mem_x, a_mem_y}, {8'd80, 7'd61});
    step(3);
`else
    step(2);
`endif
    check("draw1", {a_plot, a_x, a_y, a_col}, {1'b1, 8'd81, 7'd61, 3'b010});

    // obstacle on x only, or plain move without probing
`ifdef OBSTACLE_PROBE_EN
    step(6);
    check("probe_x_addr2", {a_mem_x, a_mem_y}, {8'd82, 7'd61});
    step(1);
    mem_a = 3'b001;
    check("chk_x_addr", a_mem_x, 81);
    step(1);
    mem_a = 3'b000;
    step(3);
    check("obstacle_draw", {a_plot, a_x, a_y, a_xdir, a_ydir}, {1'b1, 8'd81, 7'd62, 2'b01});
`else
    step(P);
    check("draw2", {a_plot, a_x, a_y, a_xdir}, {1'b1, 8'd82, 7'd62, 1'b1});
`endif

    // run dropped mid-WAIT
    step(2);
    run = 0;
    step(3);
    check("drop_busy", {a_busy, a_plot}, 2'b00);
    plots = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (a_plot) plots++;
    end
    check("drop_no_plot", plots, 0);
`ifdef OBSTACLE_PROBE_EN
    check("drop_hold_x", a_x, 81);
`else
    check("drop_hold_x", a_x, 82);
`endif
    run = 1;
    step(1);
    check("restart", {a_plot, a_x, a_y, a_busy}, {1'b1, 8'd80, 7'd60, 1'b1});

    // reset mid-frame after moving off the start point
    step(P);
    check("pre_reset", {a_x, a_y}, {8'd81, 7'd61});
`ifdef OBSTACLE_PROBE_EN
    step(9);
`else
    step(6);
`endif
    reset = 1;
    #1;
    check("rst_mid_pos", {a_x, a_y, a_mem_x, a_mem_y}, {8'd80, 7'd60, 8'd80, 7'd60});
    check("rst_mid_ctrl", {a_plot, a_busy, a_col, a_xdir, a_ydir}, {2'b00, 3'b000, 2'b11});
    step(1);
    reset = 0;
    step(1);
    check("rst_restart", {a_plot, a_x, a_y, a_col}, {1'b1, 8'd80, 7'd60, 3'b010});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
